sr_pulse_driver: RTL and testbench

//   Clocked driver for the NOR-pair SR latch: turns one-cycle set/clear requests into

---
 rtl/sr_pulse_driver_if.sv | 31 +++
 rtl/sr_pulse_driver.sv | 162 ++++++++++++++++
 tb/tb_sr_pulse_driver.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pulse_driver_if.sv
// ============================================================================
//  Module      : sr_pulse_driver_if
//  Description : Request/ack and latch drive/readback bundle for sr_pulse_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_pulse_driver_if;
    logic set_req;
    logic clr_req;
    logic ready;
    logic s;
    logic r;
    logic q_fb;
    logic _q_fb;
    logic done;
    logic fault;

    // Control logic plus the latch readback pins: drives requests and feedback.
    modport master (
        output set_req, clr_req, q_fb, _q_fb,
        input  ready, s, r, done, fault
    );

    modport slave (
        input  set_req, clr_req, q_fb, _q_fb,
        output ready, s, r, done, fault
    );
endinterface

`default_nettype wire

// File: rtl/sr_pulse_driver.sv
// ============================================================================
//  Module      : sr_pulse_driver
//  Description : Turns one-cycle set/clear requests into non-overlapping s/r
//                pulses for a NOR SR latch and confirms the flip via readback.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_pulse_driver #(
    parameter int PULSE_CYCLES   = 2,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             _reset,
    sr_pulse_driver_if.slave bus
);

    localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] C_INIT_LOAD    = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] C_PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] C_TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LOAD     = CW'(GAP_LOAD_I);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            target_q, target_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [1:0]      fb_meta_q, fb_meta_d;
    logic [1:0]      fb_sync_q, fb_sync_d;
    logic            match_q, match_d;

    logic [1:0]      w_expected;
    state_t          w_after_state;

    assign w_expected    = target_q ? 2'b10 : 2'b01;
    assign w_after_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        done_d    = 1'b0;
        fault_d   = fault_q;
        fb_meta_d = {bus.q_fb, bus._q_fb};
        fb_sync_d = fb_meta_q;
        // 00/11 can never equal the 10/01 target, so they never confirm.
        match_d   = (fb_sync_q == w_expected);

        case (state_q)
            ST_INIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = w_after_state;
                    cnt_d   = C_GAP_LOAD;
                end
            end
            ST_IDLE: begin
                if (bus.set_req || bus.clr_req) begin
                    target_d = bus.set_req & ~bus.clr_req;
                    fault_d  = 1'b0;
                    state_d  = ST_PULSE;
                    cnt_d    = C_PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_VERIFY;
                    cnt_d   = C_TIMEOUT_LOAD;
                end
            end
            ST_VERIFY: begin
                // A confirmed match holds VERIFY for the single done cycle.
                if (done_q) begin
                    state_d = w_after_state;
                    cnt_d   = C_GAP_LOAD;
                end else if (match_q) begin
                    done_d = 1'b1;
                end else if (cnt_q == '0) begin
                    fault_d = 1'b1;
                    state_d = w_after_state;
                    cnt_d   = C_GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = C_INIT_LOAD;
            end
        endcase

        s_d     = (state_d == ST_PULSE) &  target_d;
        r_d     = (state_d == ST_INIT) | ((state_d == ST_PULSE) & ~target_d);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= ST_INIT;
            // The partial cycle before the first edge is not counted, so INIT
            // still shows r=1 for PULSE_CYCLES full cycles after release.
            cnt_q     <= C_INIT_LOAD;
            target_q  <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            fb_meta_q <= 2'b01;
            fb_sync_q <= 2'b01;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            s_q       <= s_d;
            r_q       <= r_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            fb_meta_q <= fb_meta_d;
            fb_sync_q <= fb_sync_d;
            match_q   <= match_d;
        end
    end

    assign bus.s     = s_q;
    assign bus.r     = r_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.fault = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_pulse_driver.sv
// ============================================================================
//  Module      : tb_sr_pulse_driver
//  Description : Self-checking bench for sr_pulse_driver with an NOR-latch model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_pulse_driver;

    localparam int P = 2;
    localparam int G = 1;
    localparam int T = 8;

    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_OP   = 2;

    logic clk;
    logic _reset;
    logic q_lat;
    logic stuck_en;

    int checks = 0;
    int errors = 0;

    sr_pulse_driver_if bus ();

    sr_pulse_driver #(
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NOR latch: holds when s=r=0.
    initial q_lat = 1'b0;
    always @(bus.s, bus.r) begin
        if (bus.s)      q_lat = 1'b1;
        else if (bus.r) q_lat = 1'b0;
    end

    assign bus.q_fb  = stuck_en ? 1'b0 : q_lat;
    assign bus._q_fb = stuck_en ? 1'b1 : ~q_lat;

    // Timeline model: each operation is placed on a cycle axis relative to its
    // acceptance edge (cycle 1 = first cycle after acceptance).
    int         m_phase = M_INIT;
    int         m_n     = 0;
    int         m_init  = 0;
    int         m_t0    = 0;
    int         m_done_at  = -1;
    int         m_ready_at = -1;
    logic       m_tgt   = 1'b0;
    logic [1:0] m_hist [64];
    logic       ex_s = 1'b0, ex_r = 1'b1, ex_ready = 1'b0, ex_done = 1'b0, ex_fault = 1'b0;

    always @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            m_phase  = M_INIT;
            m_init   = 0;
            ex_s     = 1'b0;
            ex_r     = 1'b1;
            ex_ready = 1'b0;
            ex_done  = 1'b0;
            ex_fault = 1'b0;
        end else begin
            int rel;
            int j;
            logic [1:0] want;
            m_n = m_n + 1;
            m_hist[m_n % 64] = {bus.q_fb, bus._q_fb};
            ex_done = 1'b0;
            if (m_phase == M_INIT) begin
                m_init   = m_init + 1;
                ex_s     = 1'b0;
                ex_r     = (m_init <= P);
                ex_ready = 1'b0;
                if (m_init > P + G) begin
                    m_phase  = M_IDLE;
                    ex_ready = 1'b1;
                end
            end else if (m_phase == M_IDLE) begin
                if (bus.set_req || bus.clr_req) begin
                    m_t0       = m_n;
                    m_tgt      = bus.set_req & ~bus.clr_req;
                    m_done_at  = -1;
                    m_ready_at = -1;
                    ex_fault   = 1'b0;
                    ex_ready   = 1'b0;
                    m_phase    = M_OP;
                end
            end
            if (m_phase == M_OP) begin
                rel  = m_n - m_t0 + 1;
                j    = rel - 1;
                want = m_tgt ? 2'b10 : 2'b01;
                ex_s = (rel <= P) &&  m_tgt;
                ex_r = (rel <= P) && !m_tgt;
                // Verify cycle j sees the pin value from three cycles earlier.
                if (m_ready_at < 0 && j >= P + 1 && j <= P + T) begin
                    if (m_hist[(m_t0 + j - 3) % 64] == want) begin
                        m_done_at  = rel;
                        m_ready_at = rel + G + 1;
                    end else if (j == P + T) begin
                        ex_fault   = 1'b1;
                        m_ready_at = rel + G;
                    end
                end
                ex_done = (rel == m_done_at);
                if (rel == m_ready_at) begin
                    m_phase  = M_IDLE;
                    ex_ready = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("cyc_s",     {31'd0, bus.s},     {31'd0, ex_s});
            chk("cyc_r",     {31'd0, bus.r},     {31'd0, ex_r});
            chk("cyc_ready", {31'd0, bus.ready}, {31'd0, ex_ready});
            chk("cyc_done",  {31'd0, bus.done},  {31'd0, ex_done});
            chk("cyc_fault", {31'd0, bus.fault}, {31'd0, ex_fault});
            checks = checks + 1;
            assert (!(bus.s && bus.r)) else begin
                errors = errors + 1;
                $display("FAIL s_and_r at %0t: actual=1 expected=0", $time);
            end
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.ready && k < 100) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
    endtask

    // Leaves the caller just after the acceptance edge, inside cycle 1.
    task automatic do_req(input logic set, input logic clr);
        wait_ready();
        bus.set_req = set;
        bus.clr_req = clr;
        @(posedge clk);
        #1;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
    endtask

    // Called at the negedge on which _reset is released.
    task automatic init_checks(input string tag);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                chk({tag, "_init_r"},     {31'd0, bus.r},     32'd1);
                chk({tag, "_init_s"},     {31'd0, bus.s},     32'd0);
                chk({tag, "_init_ready"}, {31'd0, bus.ready}, 32'd0);
            end else if (c == 3) begin
                chk({tag, "_gap_r"},      {31'd0, bus.r},     32'd0);
                chk({tag, "_gap_ready"},  {31'd0, bus.ready}, 32'd0);
            end else begin
                chk({tag, "_idle_ready"}, {31'd0, bus.ready}, 32'd1);
            end
        end
        chk({tag, "_latch_q"}, {31'd0, q_lat}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog at %0t: actual=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cnt;
        int d_cnt;
        _reset      = 1'b1;
        stuck_en    = 1'b0;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        #1 _reset = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (2) @(negedge clk);
        _reset = 1'b1;
        init_checks("por");

        // Set: s on cycles 1-2, done on 5, ready back on 7.
        do_req(1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 2) chk("set_s_hi", {31'd0, bus.s}, 32'd1);
            if (c == 3) chk("set_s_lo", {31'd0, bus.s}, 32'd0);
            if (c == 4) chk("set_done_early", {31'd0, bus.done}, 32'd0);
            if (c == 5) chk("set_done",       {31'd0, bus.done}, 32'd1);
            if (c == 6) chk("set_ready_lo",   {31'd0, bus.ready}, 32'd0);
            if (c == 7) chk("set_ready_hi",   {31'd0, bus.ready}, 32'd1);
        end
        chk("set_latch_q", {31'd0, q_lat}, 32'd1);

        // Both requests: clear wins.
        do_req(1'b1, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("both_s_lo", {31'd0, bus.s}, 32'd0);
            if (c <= 2) chk("both_r_hi", {31'd0, bus.r}, 32'd1);
            if (c == 3) chk("both_r_lo", {31'd0, bus.r}, 32'd0);
            if (c == 5) chk("both_done", {31'd0, bus.done}, 32'd1);
        end
        chk("both_latch_q", {31'd0, q_lat}, 32'd0);

        // Stuck feedback on a set: timeout fault, no done.
        stuck_en = 1'b1;
        do_req(1'b1, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("stuck_no_done", {31'd0, bus.done}, 32'd0);
            if (c == 10) chk("stuck_fault_lo", {31'd0, bus.fault}, 32'd0);
            if (c == 11) chk("stuck_fault_hi", {31'd0, bus.fault}, 32'd1);
            if (c == 14) chk("stuck_fault_sticky", {31'd0, bus.fault}, 32'd1);
        end
        stuck_en = 1'b0;
        do_req(1'b0, 1'b1);
        @(negedge clk);
        chk("fault_cleared", {31'd0, bus.fault}, 32'd0);

        // Requests during PULSE/VERIFY are ignored.
        do_req(1'b1, 1'b0);
        s_cnt = 0;
        d_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.s)    s_cnt = s_cnt + 1;
            if (bus.done) d_cnt = d_cnt + 1;
            if (c == 2 || c == 4) bus.set_req = 1'b1;
            if (c == 3 || c == 5) bus.set_req = 1'b0;
        end
        chk("ignore_s_cycles", s_cnt, 32'd2);
        chk("ignore_done_cnt", d_cnt, 32'd1);

        // Reset in the middle of a set pulse.
        do_req(1'b1, 1'b0);
        @(negedge clk);
        chk("midrst_s_before", {31'd0, bus.s}, 32'd1);
        #2 _reset = 1'b0;
        #1;
        chk("midrst_s_async", {31'd0, bus.s}, 32'd0);
        chk("midrst_r_async", {31'd0, bus.r}, 32'd1);
        repeat (3) @(negedge clk);
        _reset = 1'b1;
        init_checks("midrst");

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
